// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and defaults for the ALU operation sequencer.
// Holds the FSM state encoding and default operand, selector and counter widths.
package alu_op_sequencer_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int SEL_W_DEF  = 3;
    localparam int CNT_W_DEF  = 8;

    localparam logic [2:0] ST_GET_A  = 3'd0;
    localparam logic [2:0] ST_GET_B  = 3'd1;
    localparam logic [2:0] ST_GET_OP = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    typedef enum logic [2:0] {
        GET_A  = ST_GET_A,
        GET_B  = ST_GET_B,
        GET_OP = ST_GET_OP,
        EXEC   = ST_EXEC,
        RESP   = ST_RESP
    } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer.sv
// Collects A, B and opcode bytes, drives the external ALU and returns the registered result.
// Latency: 2 cycles from the opcode handshake to res_valid; input stalls (in_ready=0) in EXEC/RESP.
// Backpressure: the result is held with res_valid until res_ready; abort drops any partial command.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEL_W  = SEL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              abort,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic              res_err,
    output logic [CNT_W-1:0]  op_count
);

    seq_state_t state, state_nxt;

    logic collecting;
    logic ld_a, ld_b, ld_op, cap_res, res_take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= GET_A;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        collecting = 1'b0;
        res_valid  = 1'b0;
        case (state)
            GET_A: begin
                collecting = 1'b1;
                if (in_valid) state_nxt = GET_B;
            end
            GET_B: begin
                collecting = 1'b1;
                if (abort)         state_nxt = GET_A;
                else if (in_valid) state_nxt = GET_OP;
            end
            GET_OP: begin
                collecting = 1'b1;
                if (abort)         state_nxt = GET_A;
                else if (in_valid) state_nxt = EXEC;
            end
            EXEC: begin
                state_nxt = abort ? GET_A : RESP;
            end
            RESP: begin
                res_valid = 1'b1;
                if (abort || res_ready) state_nxt = GET_A;
            end
            default: state_nxt = GET_A;
        endcase
    end

    // An aborted byte is refused rather than silently swallowed; abort is ignored in GET_A.
    assign in_ready = collecting && !(abort && state != GET_A);

    assign ld_a     = (state == GET_A)  && in_valid;
    assign ld_b     = (state == GET_B)  && in_valid && !abort;
    assign ld_op    = (state == GET_OP) && in_valid && !abort;
    assign cap_res  = (state == EXEC)   && !abort;
    assign res_take = (state == RESP)   && res_ready && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= '0;
            res_err  <= 1'b0;
            res_data <= '0;
            res_zero <= 1'b0;
            op_count <= '0;
        end else begin
            if (ld_a) alu_a <= in_data;
            if (ld_b) alu_b <= in_data;
            if (ld_op) begin
                alu_sel <= in_data[SEL_W-1:0];
                res_err <= |in_data[DATA_W-1:SEL_W];
            end
            if (cap_res) begin
                res_data <= alu_out;
                res_zero <= alu_zero;
            end
            if (res_take) op_count <= op_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural 8-bit ALU attached.
// Directed vector table, hand-written abort/reset sequences, and random streams with a scoreboard.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       abort = 1'b0;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_sel;
    logic [7:0] alu_out;
    logic       alu_zero;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
    logic       res_zero;
    logic       res_err;
    logic [7:0] op_count;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_cnt = 8'h00;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel);
        case (sel)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~(a & b);
            3'd6: return {a[6:0], 1'b0};
            default: return {1'b0, a[7:1]};
        endcase
    endfunction

    assign alu_out  = alu_ref(alu_a, alu_b, alu_sel);
    assign alu_zero = (alu_out == 8'h00);

    alu_op_sequencer #(.DATA_W(8), .SEL_W(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .abort(abort),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_zero(res_zero), .res_err(res_err),
        .op_count(op_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) check("send_timeout", 64'd1, 64'd0);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_cmd(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input int hold,
                           input logic [7:0] e_data, input logic e_zero, input logic e_err);
        int         lat;
        logic [7:0] held;
        send_byte(a);
        send_byte(b);
        send_byte(op);
        lat = 1;
        while (!res_valid && lat < 10) begin
            tick();
            lat++;
        end
        check({name, "_latency"}, lat, 2);
        check({name, "_data"}, res_data, e_data);
        check({name, "_zero"}, res_zero, e_zero);
        check({name, "_err"},  res_err,  e_err);
        check({name, "_sel"},  alu_sel,  op[2:0]);
        held = res_data;
        for (int i = 0; i < hold; i++) begin
            tick();
            check({name, "_hold_valid"}, res_valid, 1'b1);
            check({name, "_hold_data"},  res_data,  held);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        exp_cnt++;
        check({name, "_valid_drop"}, res_valid, 1'b0);
        check({name, "_count"}, op_count, exp_cnt);
    endtask

    // Scoreboard: every third accepted byte closes a command whose result is predicted up front.
    task automatic stream(input string name, input int nops, input bit gaps);
        logic [7:0] bytes[$];
        logic [9:0] expq[$];
        logic [7:0] a, b, op, r;
        logic       acc, cons;
        int         idx, got, cyc;
        for (int k = 0; k < nops; k++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            op = 8'($urandom);
            bytes.push_back(a);
            bytes.push_back(b);
            bytes.push_back(op);
            r = alu_ref(a, b, op[2:0]);
            expq.push_back({(op[7:3] != 5'd0), (r == 8'h00), r});
        end
        idx = 0;
        got = 0;
        cyc = 0;
        while (got < nops && cyc < nops * 20) begin
            in_valid  = (idx < bytes.size()) && (!gaps || $urandom_range(0, 3) != 0);
            in_data   = (idx < bytes.size()) ? bytes[idx] : 8'h00;
            res_ready = !gaps || ($urandom_range(0, 1) == 1);
            acc  = in_valid && in_ready;
            cons = res_valid && res_ready;
            if (cons) begin
                check({name, "_data"}, {res_err, res_zero, res_data}, expq[got]);
                check({name, "_count"}, op_count, exp_cnt);
                got++;
                exp_cnt++;
            end
            tick();
            if (acc) idx++;
            cyc++;
        end
        in_valid  = 1'b0;
        res_ready = 1'b0;
        check({name, "_ops_done"}, got, nops);
        check({name, "_bytes_used"}, idx, 3 * nops);
        check({name, "_final_count"}, op_count, exp_cnt);
    endtask

    typedef struct {
        logic [7:0] a, b, op;
        int         hold;
        logic [7:0] e_data;
        logic       e_zero, e_err;
    } vec_t;

    initial begin
        vec_t vecs[10];
        vecs[0] = '{8'h05, 8'h03, 8'h00, 0, 8'h08, 1'b0, 1'b0};
        vecs[1] = '{8'h07, 8'h07, 8'h01, 5, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h20, 8'h05, 8'hF9, 0, 8'h1B, 1'b0, 1'b1};
        vecs[3] = '{8'h20, 8'h05, 8'h01, 0, 8'h1B, 1'b0, 1'b0};
        vecs[4] = '{8'hF0, 8'h3C, 8'h02, 1, 8'h30, 1'b0, 1'b0};
        vecs[5] = '{8'hF0, 8'h0F, 8'h03, 0, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{8'hAA, 8'hAA, 8'h04, 0, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'h0F, 8'hFF, 8'h0D, 0, 8'hF0, 1'b0, 1'b1};
        vecs[8] = '{8'h81, 8'h00, 8'h06, 2, 8'h02, 1'b0, 1'b0};
        vecs[9] = '{8'h01, 8'h55, 8'h07, 0, 8'h00, 1'b1, 1'b0};

        // Reset state, then a reset arriving while waiting for B.
        #1;
        check("reset_outs", {res_valid, res_data, res_zero, res_err, op_count, alu_a, alu_b, alu_sel}, 64'd0);
        check("reset_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        send_byte(8'h11);
        check("a_latched", alu_a, 8'h11);
        check("in_ready_get_b", in_ready, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("midcmd_reset_outs", {res_valid, res_data, res_zero, res_err, op_count, alu_a, alu_b, alu_sel}, 64'd0);
        check("midcmd_reset_in_ready", in_ready, 1'b1);
        #1 rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].hold,
                    vecs[i].e_data, vecs[i].e_zero, vecs[i].e_err);
        end

        // abort in GET_OP, with a same-cycle opcode byte that must be discarded
        send_byte(8'h33);
        send_byte(8'h44);
        in_valid = 1'b1;
        in_data  = 8'h00;
        abort    = 1'b1;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("abort_op_no_valid", res_valid, 1'b0);
            tick();
        end
        check("abort_op_count", op_count, exp_cnt);
        check("abort_op_in_ready", in_ready, 1'b1);
        run_cmd("after_abort_op", 8'h09, 8'h04, 8'h01, 0, 8'h05, 1'b0, 1'b0);

        // abort in EXEC
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h00);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("abort_exec_no_valid", res_valid, 1'b0);
            tick();
        end
        check("abort_exec_count", op_count, exp_cnt);

        // abort in RESP beats a same-cycle res_ready
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h00);
        tick();
        check("resp_valid_before_abort", res_valid, 1'b1);
        abort     = 1'b1;
        res_ready = 1'b1;
        tick();
        abort     = 1'b0;
        res_ready = 1'b0;
        check("abort_resp_valid", res_valid, 1'b0);
        check("abort_resp_count", op_count, exp_cnt);
        run_cmd("after_abort_resp", 8'h10, 8'h01, 8'h06, 0, 8'h20, 1'b0, 1'b0);

        // 256 back-to-back ops from a fresh counter wrap op_count to 0
        rst = 1'b1;
        #2 rst = 1'b0;
        exp_cnt = 8'h00;
        tick();
        stream("b2b", 256, 1'b0);
        check("wrap_to_zero", op_count, 8'h00);
        stream("gappy", 60, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
